// File: rtl/rpsc_annunciator.sv
// rpsc_annunciator: RPSC front-panel annunciator and card-control sequencer.
// Synchronises latched-alarm lines and panel buttons, drives lamps/horn with
// blink-until-acknowledged behaviour, records the first-out channel, and
// sequences the card reset pulse and lamp-test drive back to the FF cards.
//
// Handshake note: there is no valid/ready traffic in this block. Every output
// is a register whose value is meaningful on every cycle after reset release.
// dbg_state mirrors the sequencer state register for observation.
module rpsc_annunciator #(
    parameter int N_CH             = 8,
    parameter int BLINK_DIV        = 25_000_000,
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LT_CYCLES        = 50_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] la_in,
    input  logic            ack_btn,
    input  logic            reset_btn,
    input  logic            lt_btn,
    output logic [N_CH-1:0] lamp,
    output logic            horn,
    output logic [N_CH-1:0] first_out,
    output logic            first_valid,
    output logic            card_reset,
    output logic            card_la_test,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RST    = 2'd1,
        S_SETTLE = 2'd2,
        S_LT     = 2'd3
    } seq_state_t;

    // One shared down-the-line counter serves RST, SETTLE and LT, so it is
    // sized for the longest of the three phases.
    localparam int SEQ_MAX_A = (RST_PULSE_CYCLES > LT_CYCLES) ? RST_PULSE_CYCLES : LT_CYCLES;
    localparam int SEQ_MAX   = (SEQ_MAX_A > 3) ? SEQ_MAX_A : 3;
    localparam int SEQ_W     = $clog2(SEQ_MAX);
    localparam int BLINK_W   = $clog2(BLINK_DIV);

    localparam logic [SEQ_W-1:0]   RST_LAST    = SEQ_W'(RST_PULSE_CYCLES - 1);
    localparam logic [SEQ_W-1:0]   SETTLE_LAST = SEQ_W'(2);
    localparam logic [SEQ_W-1:0]   LT_LAST     = SEQ_W'(LT_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);

    // Button vector layout: [0] ack, [1] reset, [2] lamp test.
    logic [N_CH-1:0]    la_s1, la_s, la_d;
    logic [2:0]         btn_s1, btn_s, btn_d;
    logic [2:0]         btn_edge;

    seq_state_t         state_q, state_d;
    logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_ph_q, blink_ph_d;

    logic [N_CH-1:0]    unack_q, unack_d;
    logic [N_CH-1:0]    first_d;
    logic               first_valid_d;

    logic [N_CH-1:0]    rise, lowest_rise;
    logic               idle, ack_ev, rst_ev, lt_ev;

    logic [N_CH-1:0]    lamp_d;
    logic               horn_d, card_reset_d, card_la_test_d, busy_d;

    // Two-flop synchronisers for alarm lines and buttons, plus delayed copies
    // used for rise/edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            la_s1  <= '0;
            la_s   <= '0;
            la_d   <= '0;
            btn_s1 <= '0;
            btn_s  <= '0;
            btn_d  <= '0;
        end else begin
            la_s1  <= la_in;
            la_s   <= la_s1;
            la_d   <= la_s;
            btn_s1 <= {lt_btn, reset_btn, ack_btn};
            btn_s  <= btn_s1;
            btn_d  <= btn_s;
        end
    end

    // Event decode: button edges are only honoured in IDLE, reset beats lamp
    // test, and rises are masked while the cards settle after a reset pulse.
    always_comb begin
        btn_edge = btn_s & ~btn_d;
        idle     = (state_q == S_IDLE);
        ack_ev   = idle & btn_edge[0];
        rst_ev   = idle & btn_edge[1];
        lt_ev    = idle & btn_edge[2] & ~btn_edge[1];
        rise     = (state_q == S_SETTLE) ? '0 : (la_s & ~la_d);
        // Scan high-to-low so the last hit, the lowest index, wins.
        lowest_rise = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rise[i]) begin
                lowest_rise    = '0;
                lowest_rise[i] = 1'b1;
            end
        end
    end

    // Unacknowledged flags and first-out capture; a rise in the ack cycle
    // keeps its channel flagged.
    always_comb begin
        unack_d       = unack_q | rise;
        first_d       = first_out;
        first_valid_d = first_valid;
        if (rst_ev) begin
            unack_d = '0;
        end else if (ack_ev) begin
            unack_d = rise;
        end
        if (rst_ev) begin
            first_d       = '0;
            first_valid_d = 1'b0;
        end else if (!first_valid && (|rise)) begin
            first_d       = lowest_rise;
            first_valid_d = 1'b1;
        end
    end

    // Sequencer next-state: RST pulse, fixed 3-clock settle, lamp test.
    always_comb begin
        state_d   = state_q;
        seq_cnt_d = seq_cnt_q;
        case (state_q)
            S_IDLE: begin
                seq_cnt_d = '0;
                if (rst_ev) begin
                    state_d = S_RST;
                end else if (lt_ev) begin
                    state_d = S_LT;
                end
            end
            S_RST: begin
                if (seq_cnt_q == RST_LAST) begin
                    state_d   = S_SETTLE;
                    seq_cnt_d = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (seq_cnt_q == SETTLE_LAST) begin
                    state_d   = S_IDLE;
                    seq_cnt_d = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + 1'b1;
                end
            end
            S_LT: begin
                if (seq_cnt_q == LT_LAST) begin
                    state_d   = S_IDLE;
                    seq_cnt_d = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                seq_cnt_d = '0;
            end
        endcase
    end

    // Free-running blink divider; never paused by the sequencer.
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_ph_d  = blink_ph_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end
    end

    // Output decode from next-state values so the registered outputs line
    // up with the flags and state they describe.
    always_comb begin
        card_reset_d    = (state_d == S_RST);
        card_la_test_d  = (state_d == S_LT);
        busy_d          = (state_d != S_IDLE);
        lamp_d          = {N_CH{card_la_test_d}} |
                          (la_s & ~(unack_d & {N_CH{~blink_ph_d}}));
        horn_d          = (|unack_d) & ~card_la_test_d;
    end

    // State, flag and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            seq_cnt_q    <= '0;
            blink_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            unack_q      <= '0;
            first_out    <= '0;
            first_valid  <= 1'b0;
            lamp         <= '0;
            horn         <= 1'b0;
            card_reset   <= 1'b0;
            card_la_test <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_cnt_q    <= seq_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_ph_q   <= blink_ph_d;
            unack_q      <= unack_d;
            first_out    <= first_d;
            first_valid  <= first_valid_d;
            lamp         <= lamp_d;
            horn         <= horn_d;
            card_reset   <= card_reset_d;
            card_la_test <= card_la_test_d;
            busy         <= busy_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_rpsc_annunciator.sv
// tb_rpsc_annunciator: directed stimulus for rpsc_annunciator with a
// queue-based scoreboard. The driver pushes the expected output word (and a
// compare mask) when it issues a step; the monitor drains and compares.
module tb_rpsc_annunciator;

    localparam int W = 21;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] la_in;
    logic       ack_btn, reset_btn, lt_btn;
    logic [7:0] lamp, first_out;
    logic       horn, first_valid, card_reset, card_la_test, busy;
    logic [1:0] dbg_state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];
    string        nm_q[$];
    int           n_vec = 0;
    int           n_bad = 0;
    int           cyc;

    rpsc_annunciator #(
        .N_CH(8), .BLINK_DIV(4), .RST_PULSE_CYCLES(16), .LT_CYCLES(10)
    ) dut (
        .clk(clk), .reset(reset), .la_in(la_in),
        .ack_btn(ack_btn), .reset_btn(reset_btn), .lt_btn(lt_btn),
        .lamp(lamp), .horn(horn), .first_out(first_out),
        .first_valid(first_valid), .card_reset(card_reset),
        .card_la_test(card_la_test), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Edges since reset release; blink phase after edge n is (n/4) odd.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [W-1:0] pk(input logic [7:0] l, input logic h,
                                        input logic [7:0] fo, input logic fv,
                                        input logic cr, input logic lt,
                                        input logic bz);
        return {l, h, fo, fv, cr, lt, bz};
    endfunction

    function automatic logic [7:0] blk(input logic [7:0] v);
        return (((cyc / 4) % 2) == 1) ? v : 8'h00;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_all(input string nm, input logic [7:0] l, input logic h,
                           input logic [7:0] fo, input logic fv, input logic cr,
                           input logic lt, input logic bz);
        exp_q.push_back(pk(l, h, fo, fv, cr, lt, bz));
        msk_q.push_back('1);
        nm_q.push_back(nm);
    endtask

    task automatic exp_lamp(input string nm, input logic [7:0] l);
        exp_q.push_back(pk(l, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        msk_q.push_back(pk(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        nm_q.push_back(nm);
    endtask

    task automatic press(input int which);
        if (which == 0) ack_btn = 1'b1;
        if (which == 1) reset_btn = 1'b1;
        if (which == 2) lt_btn = 1'b1;
        tick(1);
        ack_btn = 1'b0; reset_btn = 1'b0; lt_btn = 1'b0;
    endtask

    // Monitor: compare every queued expectation away from the clock edge.
    initial begin
        logic [W-1:0] e, m, act;
        string        s;
        forever begin
            @(posedge clk);
            #3;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m = msk_q.pop_front();
                s = nm_q.pop_front();
                act = pk(lamp, horn, first_out, first_valid, card_reset, card_la_test, busy);
                n_vec++;
                if ((act & m) !== (e & m)) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h (mask %h) t=%0t",
                             s, act & m, e & m, m, $time);
                end
            end
        end
    end

    // Driver
    initial begin
        reset = 1'b0; la_in = 8'h00;
        ack_btn = 1'b0; reset_btn = 1'b0; lt_btn = 1'b0;
        tick(3);
        exp_all("reset_state", 8'h00, 0, 8'h00, 0, 0, 0, 0);
        reset = 1'b1;
        tick(3);
        exp_all("idle_after_reset", 8'h00, 0, 8'h00, 0, 0, 0, 0);

        // Single alarm, blink until acknowledged
        la_in = 8'h04;
        tick(3);
        exp_all("la04_capture", blk(8'h04), 1, 8'h04, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            exp_lamp($sformatf("la04_blink_%0d", i), blk(8'h04));
        end
        press(0);
        tick(2);
        exp_all("ack_steady", 8'h04, 0, 8'h04, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            exp_lamp($sformatf("ack_steady_%0d", i), 8'h04);
        end

        // New alarm after first-out held
        la_in = 8'h01;
        tick(3);
        exp_all("later_rise_bit0", blk(8'h01), 1, 8'h04, 1, 0, 0, 0);

        // Reset sequence; lt_btn inside the busy window is discarded
        press(1);
        for (int off = 2; off <= 26; off++) begin
            tick(1);
            if (off == 6) lt_btn = 1'b1;
            if (off == 7) lt_btn = 1'b0;
            if (off >= 3)
                exp_all($sformatf("rst_seq_%0d", off), 8'h01, 0, 8'h00, 0,
                        (off <= 18), 0, (off <= 21));
        end

        // Lamp test with a new alarm arriving during it
        press(2);
        for (int off = 2; off <= 16; off++) begin
            tick(1);
            if (off == 4) la_in = 8'h09;
            if (off >= 3)
                exp_all($sformatf("lt_seq_%0d", off),
                        (off <= 12) ? 8'hFF : (8'h01 | blk(8'h08)),
                        (off >= 13),
                        (off >= 7) ? 8'h08 : 8'h00, (off >= 7),
                        0, (off <= 12), (off <= 12));
        end

        // Clear with alarms gone
        la_in = 8'h00;
        press(1);
        tick(25);
        exp_all("post_rst2", 8'h00, 0, 8'h00, 0, 0, 0, 0);

        // Simultaneous rises resolve to lowest index
        la_in = 8'h28;
        tick(3);
        exp_all("simul_rise_lowest", blk(8'h28), 1, 8'h08, 1, 0, 0, 0);
        press(0);
        tick(2);
        exp_all("ack_28", 8'h28, 0, 8'h08, 1, 0, 0, 0);
        la_in = 8'h29;
        tick(3);
        exp_all("late_rise_keeps_first", 8'h28 | blk(8'h01), 1, 8'h08, 1, 0, 0, 0);
        la_in = 8'h2B;
        tick(3);
        exp_all("bit1_unacked", 8'h28 | blk(8'h03), 1, 8'h08, 1, 0, 0, 0);

        // Ack and rise of bit 6 in the same cycle
        la_in = 8'h6B;
        press(0);
        tick(2);
        exp_all("ack_vs_rise6", 8'h2B | blk(8'h40), 1, 8'h08, 1, 0, 0, 0);
        press(0);
        tick(2);
        exp_all("ack_all", 8'h6B, 0, 8'h08, 1, 0, 0, 0);

        // Asynchronous reset in the middle of RST
        press(1);
        tick(7);
        exp_all("rst_active", 8'h6B, 0, 8'h00, 0, 1, 0, 1);
        tick(1);
        reset = 1'b0;
        exp_all("async_reset", 8'h00, 0, 8'h00, 0, 0, 0, 0);
        tick(2);
        exp_all("reset_held", 8'h00, 0, 8'h00, 0, 0, 0, 0);
        reset = 1'b1;
        tick(1);
        exp_all("idle_after_release", 8'h00, 0, 8'h00, 0, 0, 0, 0);
        tick(2);
        exp_all("rerise_after_reset", blk(8'h6B), 1, 8'h01, 1, 0, 0, 0);

        tick(2);
        #5;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
